fsm_ascon_ctrl: RTL
===================

Name: fsm_ascon_ctrl

Overview:
Sequencer for the Ascon-128 core in the Spartan top level. It runs one encryption per Start_ascon pulse from fsm_uart: initialisation, one associated-data block and 23 plaintext blocks, with finalisation on the last block. It owns the 5-bit word-select counter that picks the 64-bit word from the AD/wave mux. It also drives the ascon_reg capture strobes, so the cipher words are stored as the core produces them.

Parameters:
NBLOCKS, 23, number of 64-bit plaintext blocks; mux index 0 is AD, indices 1..NBLOCKS are plaintext.
CPT_W, 5, counter width; must satisfy 2^CPT_W > NBLOCKS.
TIMEOUT_CYC, 65535, maximum cycles spent in any WAIT state before an error is flagged.

Ports:
clock_i  in  1  main clock, all logic on the rising edge
resetb_i  in  1  reset, asynchronous and active-low
start_i  in  1  one-cycle start pulse (Start_ascon from fsm_uart)
end_initialisation_i  in  1  Ascon initialisation complete
end_associate_i  in  1  AD block absorbed
cipher_valid_i  in  1  cipher word on the core output is valid
end_cipher_i  in  1  plaintext block processing complete
end_tag_i  in  1  tag ready after finalisation
init_o  out  1  one-cycle pulse that starts Ascon initialisation
associate_data_o  out  1  marks the current data_valid as the AD block
finalisation_o  out  1  marks the current data_valid as the last block
data_valid_o  out  1  one-cycle pulse that injects mux word cpt_o into the core
init_cpt_mux_o  out  1  clears the counter and ascon_reg
en_cpt_mux_o  out  1  increments the counter
en_reg_ascon_o  out  1  ascon_reg capture strobe
cpt_o  out  CPT_W  current mux word index
busy_o  out  1  high in every state except IDLE and ERROR
done_o  out  1  one-cycle pulse when the encryption completes
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, resetb_i=0): state IDLE, cpt_o=0, timeout counter=0, all outputs 0.
- Counter: init_cpt_mux_o sets cpt to 0 on the next edge; otherwise en_cpt_mux_o increments it on the next edge; otherwise it holds. cpt_o never exceeds NBLOCKS.
- Strobe outputs are Moore, decoded from the state, except en_reg_ascon_o, which is combinational:
  - en_reg_ascon_o = cipher_valid_i AND (state is WAIT_PT or WAIT_FIN).
  - This makes ascon_reg capture in the same cycle the cipher word is valid.
- States and transitions:
  - IDLE: on start_i, go to INIT.
  - INIT (1 cycle): init_o=1, init_cpt_mux_o=1. Go to WAIT_INIT.
  - WAIT_INIT: on end_initialisation_i, go to AD.
  - AD (1 cycle): data_valid_o=1, associate_data_o=1, cpt=0. Go to WAIT_AD.
  - WAIT_AD: on end_associate_i, pulse en_cpt_mux_o in that cycle and go to PT.
  - PT (1 cycle): data_valid_o=1. Go to WAIT_PT.
  - WAIT_PT: on end_cipher_i, pulse en_cpt_mux_o. Go to FIN if cpt_o==NBLOCKS-1, else go to PT.
  - FIN (1 cycle): data_valid_o=1, finalisation_o=1, cpt=NBLOCKS. Go to WAIT_FIN.
  - WAIT_FIN: on end_tag_i, go to DONE.
  - DONE (1 cycle): done_o=1. Go to IDLE.
  - ERROR: err_o=1. On start_i, clear err_o and go to INIT (restart).
- Latency: start_i to init_o is 1 cycle. end_tag_i to done_o is 1 cycle.
- start_i is ignored while busy_o=1.
- Simultaneous events:
  - cipher_valid_i and end_cipher_i in the same WAIT_PT cycle: capture and advance in that cycle.
  - cipher_valid_i and end_tag_i in the same WAIT_FIN cycle: capture, then go to DONE.
  - Event inputs arriving in non-waiting states are ignored.
- Timeout: the counter clears on every state change and increments while in any WAIT state. On reaching TIMEOUT_CYC, go to ERROR. busy_o=0 in ERROR.
- Reset mid-operation: immediate return to IDLE with cpt=0. ascon_reg content is not cleared until the next INIT.
- Per encryption, with no error: exactly 1 init_o, NBLOCKS+1 data_valid_o, 1 associate_data_o, 1 finalisation_o, 1 init_cpt_mux_o, NBLOCKS en_cpt_mux_o, 1 done_o.

Test Plan:
- Nominal run, core model responding after 12 cycles to each request -> data_valid_o count 24; cpt_o sequence 0,1..23; finalisation_o coincides with cpt_o=23; 23 en_reg_ascon_o pulses; done_o exactly 1 cycle after end_tag_i.
- start_i pulsed during WAIT_PT at cpt_o=5 -> no restart, no extra init_o, run completes normally.
- cipher_valid_i and end_cipher_i asserted together at cpt_o=22 -> en_reg_ascon_o=1 and en_cpt_mux_o=1 in the same cycle; next state FIN with cpt_o=23.
- TIMEOUT_CYC=100, end_associate_i withheld -> err_o=1 after 100 cycles in WAIT_AD, busy_o=0; next start_i -> err_o=0 and init_o pulses one cycle later.
- resetb_i low for 1 cycle while in WAIT_PT at cpt_o=10 -> outputs 0 and cpt_o=0 asynchronously; a new start_i gives a full clean run.
- Two back-to-back encryptions, second start_i issued the cycle after done_o -> second run identical; init_cpt_mux_o resets cpt_o to 0.

Source files
------------

// File: rtl/fsm_ascon_ctrl.sv
// fsm_ascon_ctrl: sequences one Ascon-128 encryption (init, AD block, NBLOCKS plaintext blocks, finalisation)
// Ports:
//   clock_i, resetb_i            clock (rising edge), asynchronous active-low reset
//   start_i                      one-cycle start pulse from fsm_uart
//   end_initialisation_i, end_associate_i, end_cipher_i, end_tag_i, cipher_valid_i
//                                completion / valid events from the Ascon core
//   init_o, associate_data_o, finalisation_o, data_valid_o
//                                Ascon core control strobes
//   init_cpt_mux_o, en_cpt_mux_o, cpt_o
//                                word-select counter clear / increment / value
//   en_reg_ascon_o               ascon_reg capture strobe
//   busy_o, done_o, err_o        status: running, completion pulse, sticky timeout
module fsm_ascon_ctrl #(
   parameter int NBLOCKS     = 23,
   parameter int CPT_W       = 5,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             start_i,
   input  logic             end_initialisation_i,
   input  logic             end_associate_i,
   input  logic             cipher_valid_i,
   input  logic             end_cipher_i,
   input  logic             end_tag_i,
   output logic             init_o,
   output logic             associate_data_o,
   output logic             finalisation_o,
   output logic             data_valid_o,
   output logic             init_cpt_mux_o,
   output logic             en_cpt_mux_o,
   output logic             en_reg_ascon_o,
   output logic [CPT_W-1:0] cpt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {
      IDLE, INIT, WAIT_INIT, AD, WAIT_AD, PT, WAIT_PT, FIN, WAIT_FIN, DONE, ERROR
   } state_t;

   state_t           state, state_d;
   logic [CPT_W-1:0] cpt;
   logic [TW-1:0]    tmo;
   logic             in_wait, tmo_hit;

   assign in_wait = state inside {WAIT_INIT, WAIT_AD, WAIT_PT, WAIT_FIN};
   // an event arriving in the last allowed wait cycle still wins over the timeout
   assign tmo_hit = tmo == TW'(TIMEOUT_CYC - 1);

   always_comb begin
      state_d      = state;
      en_cpt_mux_o = 1'b0;
      case (state)
         IDLE:      if (start_i) state_d = INIT;
         INIT:      state_d = WAIT_INIT;
         WAIT_INIT: state_d = end_initialisation_i ? AD : tmo_hit ? ERROR : WAIT_INIT;
         AD:        state_d = WAIT_AD;
         WAIT_AD: begin
            en_cpt_mux_o = end_associate_i;
            state_d      = end_associate_i ? PT : tmo_hit ? ERROR : WAIT_AD;
         end
         PT:        state_d = WAIT_PT;
         WAIT_PT: begin
            en_cpt_mux_o = end_cipher_i;
            state_d      = end_cipher_i ? ((cpt == CPT_W'(NBLOCKS - 1)) ? FIN : PT) :
                           tmo_hit ? ERROR : WAIT_PT;
         end
         FIN:       state_d = WAIT_FIN;
         WAIT_FIN:  state_d = end_tag_i ? DONE : tmo_hit ? ERROR : WAIT_FIN;
         DONE:      state_d = IDLE;
         ERROR:     if (start_i) state_d = INIT;
         default:   state_d = IDLE;
      endcase
   end

   assign init_o           = state == INIT;
   assign init_cpt_mux_o   = state == INIT;
   assign associate_data_o = state == AD;
   assign finalisation_o   = state == FIN;
   assign data_valid_o     = state inside {AD, PT, FIN};
   assign done_o           = state == DONE;
   assign err_o            = state == ERROR;
   assign busy_o           = !(state inside {IDLE, ERROR});
   // capture in the very cycle the core presents a valid cipher word
   assign en_reg_ascon_o   = cipher_valid_i && (state inside {WAIT_PT, WAIT_FIN});
   assign cpt_o            = cpt;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= IDLE;
         cpt   <= '0;
         tmo   <= '0;
      end else begin
         state <= state_d;
         cpt   <= init_cpt_mux_o ? '0 :
                  (en_cpt_mux_o && cpt != CPT_W'(NBLOCKS)) ? cpt + 1'b1 : cpt;
         tmo   <= (state_d != state || !in_wait) ? '0 : tmo + 1'b1;
      end
   end
endmodule
